ysyx_24100005_ifu: RTL and testbench

//   Instruction fetch unit upstream of the single-cycle core: takes the core's PC,

---
 rtl/ysyx_24100005_ifu.sv | 114 +++++++++++
 tb/tb_ysyx_24100005_ifu.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100005_ifu.sv
// rtl/ysyx_24100005_ifu.sv - instruction fetch unit: one AXI4-Lite-style read per fetch
// Outputs are registered or decoded from state; flushed fetches still complete on the bus.
module ysyx_24100005_ifu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_pc_valid,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_inst,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic              o_fetch_err,
  output logic [ADDR_W-1:0] o_mem_araddr,
  output logic              o_mem_arvalid,
  input  logic              i_mem_arready,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic [1:0]        i_mem_rresp,
  input  logic              i_mem_rvalid,
  output logic              o_mem_rready,
  output logic [CNT_W-1:0]  o_fetch_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_HOLD} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_inst;
  logic                r_err;
  logic [ADDR_W-1:0]   r_araddr;
  logic                r_kill;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_start;
  logic                w_misaligned;
  logic                w_discard;
  logic                w_deliver;

  assign w_start      = (r_state == S_IDLE) && !i_flush && i_pc_valid;
  assign w_misaligned = |i_pc[1:0];
  // A flush arriving in the same cycle as rvalid must also drop the data.
  assign w_discard    = r_kill || i_flush;
  assign w_deliver    = (r_state == S_HOLD) && i_inst_ready && !i_flush;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = w_misaligned ? S_HOLD : S_AR;
      S_AR:   if (i_mem_arready) w_next = S_R;
      S_R:    if (i_mem_rvalid) w_next = w_discard ? S_IDLE : S_HOLD;
      S_HOLD: if (i_flush || i_inst_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_inst   <= '0;
      r_err    <= 1'b0;
      r_araddr <= '0;
      r_kill   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_araddr <= i_pc;
            if (w_misaligned) begin
              r_inst <= '0;
              r_err  <= 1'b1;
            end
          end
        end
        S_AR: begin
          if (i_flush) r_kill <= 1'b1;
        end
        S_R: begin
          if (i_mem_rvalid) begin
            if (!w_discard) begin
              r_inst <= i_mem_rdata;
              r_err  <= |i_mem_rresp;
            end
            r_kill <= 1'b0;
          end else if (i_flush) begin
            r_kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (w_deliver) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        default: r_kill <= 1'b0;
      endcase
    end
  end

  assign o_inst        = r_inst;
  assign o_fetch_err   = r_err;
  assign o_inst_valid  = (r_state == S_HOLD);
  assign o_mem_araddr  = r_araddr;
  assign o_mem_arvalid = (r_state == S_AR);
  assign o_mem_rready  = (r_state == S_R);
  assign o_fetch_cnt   = r_cnt;

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// tb/tb_ysyx_24100005_ifu.sv - directed self-checking bench for ysyx_24100005_ifu
module tb_ysyx_24100005_ifu;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic        fetch_err;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  int          s_ar_delay = 0;
  int          s_r_delay  = 0;
  logic [31:0] s_rdata    = 32'h0;
  logic [1:0]  s_rresp    = 2'b00;
  int          ar_cnt     = 0;
  int          r_cnt      = 0;
  int          ar_hs      = 0;

  ysyx_24100005_ifu #(.ADDR_W(32), .DATA_W(32), .CNT_W(32)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_pc          (pc),
    .i_pc_valid    (pc_valid),
    .i_flush       (flush),
    .o_inst        (inst),
    .o_inst_valid  (inst_valid),
    .i_inst_ready  (inst_ready),
    .o_fetch_err   (fetch_err),
    .o_mem_araddr  (araddr),
    .o_mem_arvalid (arvalid),
    .i_mem_arready (arready),
    .i_mem_rdata   (rdata),
    .i_mem_rresp   (rresp),
    .i_mem_rvalid  (rvalid),
    .o_mem_rready  (rready),
    .o_fetch_cnt   (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: decides arready/rvalid at the falling edge from configured wait counts.
  always @(negedge clk) begin
    if (!rst) begin
      arready = 1'b0;
      rvalid  = 1'b0;
      ar_cnt  = 0;
      r_cnt   = 0;
    end else begin
      arready = 1'b0;
      rvalid  = 1'b0;
      rdata   = s_rdata;
      rresp   = s_rresp;
      if (arvalid) begin
        if (ar_cnt >= s_ar_delay) arready = 1'b1;
        else ar_cnt = ar_cnt + 1;
      end else begin
        ar_cnt = 0;
      end
      if (rready) begin
        if (r_cnt >= s_r_delay) rvalid = 1'b1;
        else r_cnt = r_cnt + 1;
      end else begin
        r_cnt = 0;
      end
    end
  end

  always @(posedge clk) begin
    if (rst && arvalid && arready) ar_hs <= ar_hs + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept;
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    pc_valid   = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({inst_valid, fetch_err, arvalid, rready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000", {inst_valid, fetch_err, arvalid, rready});
    end
    checks++;
    if (inst !== 32'h0 || araddr !== 32'h0 || fetch_cnt !== 32'h0) begin
      errors++;
      $display("FAIL reset_data inst %h araddr %h cnt %0d want all 0", inst, araddr, fetch_cnt);
    end
  endtask

  task automatic test_zero_wait;
    s_ar_delay = 0; s_r_delay = 0; s_rdata = 32'h00100093; s_rresp = 2'b00;
    pc = 32'h80000000; pc_valid = 1'b1;
    tick();
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h80000000) begin
      errors++;
      $display("FAIL zw_ar_cycle1 arvalid %b araddr %h want 1 80000000", arvalid, araddr);
    end
    tick();
    checks++;
    if (rready !== 1'b1 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL zw_r_cycle2 rready %b inst_valid %b want 1 0", rready, inst_valid);
    end
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h00100093 || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL zw_inst_cycle3 valid %b inst %h err %b want 1 00100093 0", inst_valid, inst, fetch_err);
    end
    accept();
    checks++;
    if (inst_valid !== 1'b0 || fetch_cnt !== 32'd1 || ar_hs !== 1) begin
      errors++;
      $display("FAIL zw_accept valid %b cnt %0d hs %0d want 0 1 1", inst_valid, fetch_cnt, ar_hs);
    end
  endtask

  task automatic test_wait_states;
    int hs0;
    int lat;
    int bad;
    hs0 = ar_hs; lat = 0; bad = 0;
    s_ar_delay = 5; s_r_delay = 3; s_rdata = 32'hdeadbeef; s_rresp = 2'b00;
    pc = 32'h80000010; pc_valid = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (arvalid && araddr !== 32'h80000010) bad++;
      if (inst_valid) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat !== 11) begin
      errors++;
      $display("FAIL ws_latency got %0d want 11", lat);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL ws_araddr_stable unstable cycles %0d want 0", bad);
    end
    checks++;
    if (inst !== 32'hdeadbeef || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL ws_inst got %h err %b want deadbeef 0", inst, fetch_err);
    end
    accept();
    for (int c = 0; c < 3; c++) begin
      tick();
      if (arvalid) bad++;
    end
    checks++;
    if (ar_hs - hs0 !== 1 || bad !== 0 || fetch_cnt !== 32'd2) begin
      errors++;
      $display("FAIL ws_single_hs hs %0d extra %0d cnt %0d want 1 0 2", ar_hs - hs0, bad, fetch_cnt);
    end
    s_ar_delay = 0; s_r_delay = 0;
  endtask

  task automatic test_errors;
    int hs0;
    hs0 = ar_hs;
    pc = 32'h80000002; pc_valid = 1'b1;
    tick();
    checks++;
    if (inst_valid !== 1'b1 || arvalid !== 1'b0 || inst !== 32'h0 || fetch_err !== 1'b1) begin
      errors++;
      $display("FAIL misaligned valid %b arvalid %b inst %h err %b want 1 0 0 1", inst_valid, arvalid, inst, fetch_err);
    end
    accept();
    checks++;
    if (fetch_cnt !== 32'd3 || ar_hs !== hs0) begin
      errors++;
      $display("FAIL misaligned_count cnt %0d hs %0d want 3 %0d", fetch_cnt, ar_hs, hs0);
    end
    s_rdata = 32'h12345678; s_rresp = 2'b10;
    pc = 32'h80000020; pc_valid = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h12345678 || fetch_err !== 1'b1) begin
      errors++;
      $display("FAIL slverr valid %b inst %h err %b want 1 12345678 1", inst_valid, inst, fetch_err);
    end
    accept();
    s_rresp = 2'b00;
  endtask

  task automatic test_flush_in_r;
    int seen;
    int done;
    seen = 0; done = 0;
    s_r_delay = 3; s_rdata = 32'hbad0bad0;
    pc = 32'h80000030; pc_valid = 1'b1;
    tick(); tick();
    checks++;
    if (rready !== 1'b1) begin
      errors++;
      $display("FAIL fl_in_r rready %b want 1", rready);
    end
    flush = 1'b1; pc_valid = 1'b0;
    tick();
    flush = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (inst_valid) seen++;
      if (!rready && !arvalid && !inst_valid) begin
        done = 1;
        break;
      end
      tick();
    end
    tick();
    checks++;
    if (seen !== 0 || done !== 1 || inst_valid !== 1'b0 || fetch_cnt !== 32'd4) begin
      errors++;
      $display("FAIL fl_drop seen %0d idle %0d valid %b cnt %0d want 0 1 0 4", seen, done, inst_valid, fetch_cnt);
    end
    s_r_delay = 0; s_rdata = 32'h00000013;
    pc = 32'h80000004; pc_valid = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h00000013 || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL fl_refetch valid %b inst %h err %b want 1 00000013 0", inst_valid, inst, fetch_err);
    end
    accept();
    checks++;
    if (fetch_cnt !== 32'd5) begin
      errors++;
      $display("FAIL fl_refetch_cnt got %0d want 5", fetch_cnt);
    end
  endtask

  task automatic test_hold_flush;
    int unstable;
    unstable = 0;
    s_rdata = 32'h00a00513;
    pc = 32'h80000040; pc_valid = 1'b1;
    tick(); tick(); tick();
    for (int c = 0; c < 4; c++) begin
      tick();
      if (inst_valid !== 1'b1 || inst !== 32'h00a00513 || fetch_err !== 1'b0) unstable++;
    end
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("FAIL hold_stable unstable cycles %0d want 0", unstable);
    end
    flush = 1'b1; inst_ready = 1'b1; pc_valid = 1'b0;
    tick();
    flush = 1'b0; inst_ready = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || fetch_cnt !== 32'd5) begin
      errors++;
      $display("FAIL hold_flush valid %b cnt %0d want 0 5", inst_valid, fetch_cnt);
    end
  endtask

  task automatic test_reset_in_ar;
    s_ar_delay = 100;
    pc = 32'h80000050; pc_valid = 1'b1;
    tick();
    checks++;
    if (arvalid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_ar arvalid %b want 1", arvalid);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({arvalid, rready, inst_valid, fetch_err} !== 4'b0000 || inst !== 32'h0 ||
        araddr !== 32'h0 || fetch_cnt !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_ar ctrl %b inst %h araddr %h cnt %0d want 0000 0 0 0",
               {arvalid, rready, inst_valid, fetch_err}, inst, araddr, fetch_cnt);
    end
    pc_valid = 1'b0;
    tick();
    rst = 1'b1;
    s_ar_delay = 0; s_rdata = 32'h00000073;
    pc = 32'h80000060; pc_valid = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h00000073) begin
      errors++;
      $display("FAIL rst_refetch valid %b inst %h want 1 00000073", inst_valid, inst);
    end
    accept();
    checks++;
    if (fetch_cnt !== 32'd1) begin
      errors++;
      $display("FAIL rst_refetch_cnt got %0d want 1", fetch_cnt);
    end
  endtask

  initial begin
    rst = 1'b0; pc = 32'h0; pc_valid = 1'b0; flush = 1'b0; inst_ready = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    tick(); tick();
    test_reset();
    rst = 1'b1;
    tick();
    test_zero_wait();
    test_wait_states();
    test_errors();
    test_flush_in_r();
    test_hold_flush();
    test_reset_in_ar();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
